// File: rtl/sseg_scan_decoder_if.sv
// Scan-line bundle between a multiplexed seven-segment driver (master) and a decoder watching it (slave).
// frame_valid is a bare one-cycle pulse with no ready: the consumer must take frame_value that cycle or read it later while held.
interface sseg_scan_decoder_if;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic [15:0] frame_value;
    logic        seg_err;
    logic        an_err;
    logic        stall;
    logic [1:0]  dbg_state;

    modport master (
        output an, sseg,
        input  value, dp, blank, frame_valid, frame_value, seg_err, an_err, stall, dbg_state
    );

    modport slave (
        input  an, sseg,
        output value, dp, blank, frame_valid, frame_value, seg_err, an_err, stall, dbg_state
    );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Watches active-low anode/segment scan lines, rebuilds the four shown hex digits and decimal points,
// and flags malformed scans and stalled displays.
module sseg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STALL_CYCLES  = 4096
) (
    input  logic               clk,
    input  logic               clr_n,
    sseg_scan_decoder_if.slave bus
);
    localparam int unsigned        STALL_W  = $clog2(STALL_CYCLES + 1);
    localparam logic [7:0]         SETTLE_N = 8'(SETTLE_CYCLES);
    localparam logic [STALL_W-1:0] STALL_N  = STALL_W'(STALL_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         an_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [15:0]        value_q, value_d;
    logic [15:0]        frame_value_q, frame_value_d;
    logic [3:0]         dp_q, dp_d;
    logic [3:0]         blank_q, blank_d;
    logic [3:0]         mask_q, mask_d;
    logic               frame_valid_q, frame_valid_d;
    logic               seg_err_q, seg_err_d;
    logic               an_err_q, an_err_d;

    logic       an_one_hot;
    logic [1:0] an_idx;
    logic [5:0] dec;
    logic       entry;
    logic       capture;
    logic       cap_ok;
    logic [3:0] mask_upd;

    // Result layout: {legal, blank, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   return {2'b10, 4'h0};
            7'h79:   return {2'b10, 4'h1};
            7'h24:   return {2'b10, 4'h2};
            7'h30:   return {2'b10, 4'h3};
            7'h19:   return {2'b10, 4'h4};
            7'h12:   return {2'b10, 4'h5};
            7'h02:   return {2'b10, 4'h6};
            7'h78:   return {2'b10, 4'h7};
            7'h00:   return {2'b10, 4'h8};
            7'h10:   return {2'b10, 4'h9};
            7'h08:   return {2'b10, 4'hA};
            7'h03:   return {2'b10, 4'hB};
            7'h46:   return {2'b10, 4'hC};
            7'h21:   return {2'b10, 4'hD};
            7'h06:   return {2'b10, 4'hE};
            7'h0E:   return {2'b10, 4'hF};
            7'h7F:   return {2'b11, 4'h0};
            default: return 6'b00_0000;
        endcase
    endfunction

    always_comb begin
        an_one_hot = 1'b1;
        an_idx     = 2'd0;
        case (bus.an)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_one_hot = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        value_d       = value_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        mask_d        = mask_q;
        frame_value_d = frame_value_q;
        frame_valid_d = 1'b0;
        seg_err_d     = 1'b0;
        an_err_d      = 1'b0;
        entry         = 1'b0;
        capture       = 1'b0;
        cap_ok        = 1'b0;
        mask_upd      = mask_q;
        stall_cnt_d   = stall_cnt_q;
        dec           = decode_seg(bus.sseg[6:0]);

        case (state_q)
            S_IDLE:   entry = 1'b1;
            S_SETTLE: begin
                if (bus.an != an_q) begin
                    entry = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    capture = (cnt_d >= SETTLE_N);
                end
            end
            S_HOLD:   entry = (bus.an != an_q);
            default:  entry = 1'b1;
        endcase

        // A freshly seen pattern counts as its first settled cycle, so a one-cycle settle captures here.
        if (entry) begin
            if (an_one_hot) begin
                cnt_d   = 8'd1;
                state_d = S_SETTLE;
                capture = (SETTLE_N == 8'd1);
            end else begin
                cnt_d    = 8'd0;
                state_d  = S_IDLE;
                an_err_d = (bus.an != 4'hF);
            end
        end

        if (capture) begin
            state_d = S_HOLD;
            cnt_d   = 8'd0;
            if (dec[5]) begin
                cap_ok                         = 1'b1;
                value_d[{an_idx, 2'b00} +: 4]  = dec[3:0];
                blank_d[an_idx]                = dec[4];
                dp_d[an_idx]                   = ~bus.sseg[7];
                mask_upd                       = mask_q | (4'b0001 << an_idx);
                if (mask_upd == 4'hF) begin
                    frame_valid_d = 1'b1;
                    frame_value_d = value_d;
                    mask_d        = 4'h0;
                end else begin
                    mask_d = mask_upd;
                end
            end else begin
                seg_err_d = 1'b1;
            end
        end

        if (cap_ok) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_N) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= S_IDLE;
            an_q          <= 4'hF;
            cnt_q         <= 8'd0;
            stall_cnt_q   <= '0;
            value_q       <= 16'h0;
            frame_value_q <= 16'h0;
            dp_q          <= 4'h0;
            blank_q       <= 4'h0;
            mask_q        <= 4'h0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            an_q          <= bus.an;
            cnt_q         <= cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            value_q       <= value_d;
            frame_value_q <= frame_value_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            mask_q        <= mask_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            an_err_q      <= an_err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.dp          = dp_q;
    assign bus.blank       = blank_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_value = frame_value_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.an_err      = an_err_q;
    assign bus.stall       = (stall_cnt_q == STALL_N);
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: two instances (settle 4 and settle 1) see the same scan lines and are
// compared every cycle against a dwell-length model of the decoder.
module tb_sseg_scan_decoder;
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_decoder_if bus_a ();
    sseg_scan_decoder_if bus_b ();

    sseg_scan_decoder #(.SETTLE_CYCLES(4), .STALL_CYCLES(16)) dut_a (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_a.slave)
    );

    sseg_scan_decoder #(.SETTLE_CYCLES(1), .STALL_CYCLES(16)) dut_b (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         settle_of [2]  = '{4, 1};
    logic [6:0] seg_tab   [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: run length of the current anode pattern drives everything.
    logic [3:0]  m_prev  [2];
    int          m_run   [2];
    logic [15:0] m_val   [2];
    logic [3:0]  m_dp    [2];
    logic [3:0]  m_blank [2];
    logic [3:0]  m_mask  [2];
    logic [15:0] m_fvv   [2];
    int          m_stall [2];
    logic        e_fv    [2];
    logic        e_seg   [2];
    logic        e_an    [2];

    logic [15:0] exp_q_a [$];
    logic [15:0] exp_q_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        check("sb_drain_a", 32'(exp_q_a.size()), 0);
        check("sb_drain_b", 32'(exp_q_b.size()), 0);
        exp_q_a.delete();
        exp_q_b.delete();
        for (int k = 0; k < 2; k++) begin
            m_prev[k]  = 4'hF;
            m_run[k]   = 0;
            m_val[k]   = 16'h0;
            m_dp[k]    = 4'h0;
            m_blank[k] = 4'h0;
            m_mask[k]  = 4'h0;
            m_fvv[k]   = 16'h0;
            m_stall[k] = 0;
            e_fv[k]    = 1'b0;
            e_seg[k]   = 1'b0;
            e_an[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] a, input logic [7:0] s);
        int lows;
        int d;
        int code;
        bit ok;
        lows = 0;
        d    = 0;
        ok   = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                lows++;
                d = i;
            end
        end
        e_fv[k]  = 1'b0;
        e_seg[k] = 1'b0;
        e_an[k]  = 1'b0;
        m_run[k] = (a == m_prev[k]) ? m_run[k] + 1 : 1;
        m_prev[k] = a;
        if (lows > 1) begin
            e_an[k] = 1'b1;
        end else if (lows == 1 && m_run[k] == settle_of[k]) begin
            code = -1;
            for (int i = 0; i < 16; i++) if (seg_tab[i] == s[6:0]) code = i;
            if (s[6:0] == 7'h7F) code = 16;
            if (code < 0) begin
                e_seg[k] = 1'b1;
            end else begin
                ok = 1;
                m_val[k][4*d +: 4] = (code == 16) ? 4'h0 : code[3:0];
                m_blank[k][d]      = (code == 16);
                m_dp[k][d]         = ~s[7];
                m_mask[k][d]       = 1'b1;
                if (m_mask[k] == 4'hF) begin
                    e_fv[k]   = 1'b1;
                    m_fvv[k]  = m_val[k];
                    m_mask[k] = 4'h0;
                    if (k == 0) exp_q_a.push_back(m_val[k]);
                    else        exp_q_b.push_back(m_val[k]);
                end
            end
        end
        if (ok) m_stall[k] = 0;
        else if (m_stall[k] < 16) m_stall[k]++;
    endtask

    task automatic compare(input int k, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                           input logic fv, input logic [15:0] fvv, input logic se, input logic ae,
                           input logic st);
        string nm;
        nm = (k == 0) ? "s4" : "s1";
        check({nm, ".value"}, v, m_val[k]);
        check({nm, ".dp"}, dp, m_dp[k]);
        check({nm, ".blank"}, bl, m_blank[k]);
        check({nm, ".frame_valid"}, fv, e_fv[k]);
        check({nm, ".frame_value"}, fvv, m_fvv[k]);
        check({nm, ".seg_err"}, se, e_seg[k]);
        check({nm, ".an_err"}, ae, e_an[k]);
        check({nm, ".stall"}, st, (m_stall[k] == 16));
        if (fv && k == 0 && exp_q_a.size() > 0) check("s4.frame_sb", fvv, exp_q_a.pop_front());
        if (fv && k == 1 && exp_q_b.size() > 0) check("s1.frame_sb", fvv, exp_q_b.pop_front());
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic [3:0] a, input logic [7:0] s);
        bus_a.an   = a;
        bus_a.sseg = s;
        bus_b.an   = a;
        bus_b.sseg = s;
        @(posedge clk);
        model_step(0, a, s);
        model_step(1, a, s);
        #1;
        compare(0, bus_a.value, bus_a.dp, bus_a.blank, bus_a.frame_valid, bus_a.frame_value,
                bus_a.seg_err, bus_a.an_err, bus_a.stall);
        compare(1, bus_b.value, bus_b.dp, bus_b.blank, bus_b.frame_valid, bus_b.frame_value,
                bus_b.seg_err, bus_b.an_err, bus_b.stall);
        @(negedge clk);
    endtask

    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
        repeat (n) cyc(a, s);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".value"}, bus_a.value, 0);
        check({tag, ".dp"}, bus_a.dp, 0);
        check({tag, ".blank"}, bus_a.blank, 0);
        check({tag, ".frame_value"}, bus_a.frame_value, 0);
        check({tag, ".pulses"}, {bus_a.frame_valid, bus_a.seg_err, bus_a.an_err}, 0);
        check({tag, ".stall"}, bus_a.stall, 0);
        check({tag, ".state"}, bus_a.dbg_state, 0);
        check({tag, ".b_value"}, bus_b.value, 0);
        check({tag, ".b_dp_blank"}, {bus_b.dp, bus_b.blank}, 0);
    endtask

    task automatic scan(input logic [15:0] digits, input int n);
        for (int d = 3; d >= 0; d--) begin
            dwell(4'hF ^ (4'h1 << d), {1'b1, seg_tab[digits[4*d +: 4]]}, n);
        end
    endtask

    int         r;
    int         n;
    logic [3:0] ra;
    logic [7:0] rs;

    initial begin
        bus_a.an   = 4'hF;
        bus_a.sseg = 8'hFF;
        bus_b.an   = 4'hF;
        bus_b.sseg = 8'hFF;
        clr_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("rst");
        model_reset();
        clr_n = 1'b1;

        // Blank display: stall after 16 idle cycles.
        dwell(4'hF, 8'hFF, 15);
        check("stall_pre", bus_a.stall, 0);
        dwell(4'hF, 8'hFF, 1);
        check("stall_hi", bus_a.stall, 1);

        // Single digit "3" on the rightmost position; capture also clears stall.
        dwell(4'b1110, 8'hB0, 6);
        check("digit0_is_3", bus_a.value[3:0], 4'h3);
        check("stall_cleared", bus_a.stall, 0);

        // "0032" scanned twice.
        scan(16'h0032, 8);
        scan(16'h0032, 8);
        check("frame_0032", bus_a.frame_value, 16'h0032);

        // Short glitch on digit 0, then a real dwell on digit 1.
        dwell(4'b1110, 8'hF9, 2);
        dwell(4'b1101, 8'h99, 8);

        // Undecodable segments, multi-hot anodes, blank digit with dp lit.
        dwell(4'b1110, 8'hAA, 6);
        dwell(4'b1100, 8'hC0, 1);
        dwell(4'hF, 8'hFF, 2);
        dwell(4'b1110, 8'h7F, 6);
        check("blank0", bus_a.blank[0], 1);
        check("dp0", bus_a.dp[0], 1);

        // Segment changes during hold are ignored.
        dwell(4'b1011, 8'h92, 5);
        dwell(4'b1011, 8'h80, 5);

        for (int t = 0; t < 160; t++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      ra = 4'hF ^ (4'h1 << $urandom_range(0, 3));
            else if (r < 85) ra = 4'hF;
            else             ra = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 85)      rs = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
            else if (r < 92) rs = {1'($urandom_range(0, 1)), 7'h7F};
            else             rs = 8'($urandom);
            n = $urandom_range(1, 8);
            dwell(ra, rs, n);
        end

        // Asynchronous reset after three of four digits.
        dwell(4'hF, 8'hFF, 2);
        dwell(4'b0111, 8'hF9, 6);
        dwell(4'b1011, 8'hA4, 6);
        dwell(4'b1101, 8'h99, 6);
        #2 clr_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        dwell(4'b1110, 8'h92, 6);
        check("no_partial_frame", bus_a.frame_value, 0);
        scan(16'h1245, 6);
        check("frame_after_rst", bus_a.frame_value, 16'h1245);
        dwell(4'hF, 8'hFF, 2);

        check("end_drain_a", 32'(exp_q_a.size()), 0);
        check("end_drain_b", 32'(exp_q_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
